// File: rtl/rs_dec_pkg.sv
// Shared constants and FSM state type for the RS(132,120) decoder frame scheduler.
package rs_dec_pkg;

  localparam int unsigned N_IN  = 132;
  localparam int unsigned N_OUT = 120;
  localparam int unsigned SYM_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rs_tag_fifo.sv
// In-order tag FIFO; extra pointer MSB distinguishes full from empty.
module rs_tag_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/rs_dec_frame_sched.sv
// Two-channel round-robin frame scheduler feeding the RS(132,120) decoder,
// with framing, inter-frame gap and in-order channel tagging of decoder output.
module rs_dec_frame_sched
  import rs_dec_pkg::*;
#(
  parameter int unsigned GAP       = 2,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  output logic             rd_en0,
  output logic             rd_en1,
  input  logic [SYM_W-1:0] rd_data0,
  input  logic [SYM_W-1:0] rd_data1,
  output logic             dec_din_val,
  output logic             dec_din_sop,
  output logic             dec_din_eop,
  output logic [SYM_W-1:0] dec_din,
  input  logic             dec_out_val,
  output logic             out_ch,
  output logic             out_last,
  output logic             busy,
  output logic             err_orphan
);

  localparam int unsigned GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [7:0]    IN_LAST  = 8'(N_IN - 1);
  localparam logic [6:0]    OUT_LAST = 7'(N_OUT - 1);

  sched_state_e  state_q, state_d;
  logic          sel_q, sel_d;
  logic          rr_q, rr_d;
  logic [7:0]    in_cnt_q, in_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [6:0]    out_cnt_q, out_cnt_d;
  logic          sel_dly_q;
  logic          val_q, sop_q, eop_q;
  logic          err_q;
  logic          grant_ch;
  logic          issue;

  logic          tag_push, tag_pop, tag_dout, tag_full, tag_empty;

  rs_tag_fifo #(
    .WIDTH (1),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tag_push),
    .pop   (tag_pop),
    .din   (grant_ch),
    .dout  (tag_dout),
    .full  (tag_full),
    .empty (tag_empty)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    in_cnt_d  = in_cnt_q;
    gap_cnt_d = gap_cnt_q;
    tag_push  = 1'b0;
    // Both requesting: the channel that did not win last time goes next.
    grant_ch  = (req0 && req1) ? ~rr_q : req1;
    case (state_q)
      ST_IDLE: begin
        in_cnt_d  = '0;
        gap_cnt_d = '0;
        if ((req0 || req1) && !tag_full) begin
          sel_d    = grant_ch;
          rr_d     = grant_ch;
          tag_push = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (in_cnt_q == IN_LAST) begin
          in_cnt_d = '0;
          state_d  = (GAP > 0) ? ST_GAP : ST_IDLE;
        end else begin
          in_cnt_d = in_cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign issue  = (state_q == ST_ISSUE);
  assign rd_en0 = issue && !sel_q;
  assign rd_en1 = issue && sel_q;

  // Output side: count corrected symbols; retire a tag on the last one.
  always_comb begin
    out_cnt_d = out_cnt_q;
    if (dec_out_val) out_cnt_d = (out_cnt_q == OUT_LAST) ? '0 : out_cnt_q + 7'd1;
  end

  assign out_last = dec_out_val && (out_cnt_q == OUT_LAST);
  assign tag_pop  = out_last && !tag_empty;
  assign out_ch   = tag_dout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= 1'b0;
      rr_q      <= 1'b1;
      in_cnt_q  <= '0;
      gap_cnt_q <= '0;
      out_cnt_q <= '0;
      sel_dly_q <= 1'b0;
      val_q     <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_q      <= rr_d;
      in_cnt_q  <= in_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      out_cnt_q <= out_cnt_d;
      sel_dly_q <= sel_q;
      val_q     <= issue;
      sop_q     <= issue && (in_cnt_q == '0);
      eop_q     <= issue && (in_cnt_q == IN_LAST);
      err_q     <= err_q || (dec_out_val && tag_empty);
    end
  end

  assign dec_din_val = val_q;
  assign dec_din_sop = sop_q;
  assign dec_din_eop = eop_q;
  assign dec_din     = val_q ? (sel_dly_q ? rd_data1 : rd_data0) : '0;
  assign busy        = (state_q != ST_IDLE) || !tag_empty;
  assign err_orphan  = err_q;

endmodule

// File: tb/tb_rs_dec_frame_sched.sv
// Directed self-checking bench for rs_dec_frame_sched (GAP = 2, TAG_DEPTH = 4).
module tb_rs_dec_frame_sched;

  logic       clk = 1'b0;
  logic       rst_n, req0, req1, dec_out_val;
  logic [7:0] rd_data0 = '0, rd_data1 = '0;
  logic       rd_en0, rd_en1, dec_din_val, dec_din_sop, dec_din_eop;
  logic [7:0] dec_din;
  logic       out_ch, out_last, busy, err_orphan;

  always #5 clk = ~clk;

  rs_dec_frame_sched #(
    .GAP       (2),
    .TAG_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0        (req0),
    .req1        (req1),
    .rd_en0      (rd_en0),
    .rd_en1      (rd_en1),
    .rd_data0    (rd_data0),
    .rd_data1    (rd_data1),
    .dec_din_val (dec_din_val),
    .dec_din_sop (dec_din_sop),
    .dec_din_eop (dec_din_eop),
    .dec_din     (dec_din),
    .dec_out_val (dec_out_val),
    .out_ch      (out_ch),
    .out_last    (out_last),
    .busy        (busy),
    .err_orphan  (err_orphan)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Source buffers: symbol k of a frame is k (ch0) or k+0x40 (ch1), one cycle after rd_en.
  logic [7:0] src0 = '0, src1 = '0;
  always @(posedge clk) begin
    src0 <= rd_en0 ? src0 + 8'd1 : 8'd0;
    src1 <= rd_en1 ? src1 + 8'd1 : 8'd0;
    if (rd_en0) rd_data0 <= src0;
    if (rd_en1) rd_data1 <= src1 + 8'h40;
  end

  int         n_rd0, n_rd1, n_ovl, n_val, n_sop, n_eop;
  int         sop_cyc [16];
  logic       sop_ch  [16];
  logic [7:0] sop_dat [16];
  logic [7:0] eop_dat;
  logic       prev_rd1 = 1'b0;

  always @(negedge clk) begin
    if (rd_en0) n_rd0 = n_rd0 + 1;
    if (rd_en1) n_rd1 = n_rd1 + 1;
    if (rd_en0 && rd_en1) n_ovl = n_ovl + 1;
    if (dec_din_val) n_val = n_val + 1;
    if (dec_din_sop && n_sop < 16) begin
      sop_cyc[n_sop] = cyc;
      sop_ch[n_sop]  = prev_rd1;
      sop_dat[n_sop] = dec_din;
      n_sop = n_sop + 1;
    end
    if (dec_din_eop) begin
      eop_dat = dec_din;
      n_eop   = n_eop + 1;
    end
    prev_rd1 = rd_en1;
  end

  task automatic clr_mon();
    n_rd0 = 0; n_rd1 = 0; n_ovl = 0; n_val = 0; n_sop = 0; n_eop = 0;
    eop_dat = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; dec_out_val = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    clr_mon();
  endtask

  // Drive n back-to-back dec_out_val pulses; chseq[k] is the channel expected for frame k.
  task automatic pulses(input int unsigned n, input logic [3:0] chseq, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      dec_out_val = 1'b1;
      #1;
      chk({tag, "_ch"},   {31'd0, out_ch},   {31'd0, chseq[i / 120]});
      chk({tag, "_last"}, {31'd0, out_last}, {31'd0, (i % 120) == 119});
      step();
    end
    dec_out_val = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned budget;
    logic        seen;

    // Reset state
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; dec_out_val = 1'b0;
    clr_mon();
    repeat (3) step();
    chk("rst_rd_en", {30'd0, rd_en0, rd_en1}, 32'd0);
    chk("rst_din",   {21'd0, dec_din_val, dec_din_sop, dec_din_eop, dec_din}, 32'd0);
    chk("rst_out",   {28'd0, out_ch, out_last, busy, err_orphan}, 32'd0);

    // Single req0 pulse: one 132-symbol frame on ch0
    do_reset();
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    chk("t1_rd_en0_start", {31'd0, rd_en0}, 32'd1);
    repeat (150) step();
    chk("t1_n_rd0",  n_rd0, 132);
    chk("t1_n_rd1",  n_rd1, 0);
    chk("t1_n_val",  n_val, 132);
    chk("t1_n_sop",  n_sop, 1);
    chk("t1_n_eop",  n_eop, 1);
    chk("t1_sop_dat", {24'd0, sop_dat[0]}, 32'h00);
    chk("t1_eop_dat", {24'd0, eop_dat},    32'h83);
    chk("t1_busy_tag", {31'd0, busy}, 32'd1);
    pulses(120, 4'b0000, "t1_drain");
    step();
    chk("t1_busy_idle", {31'd0, busy}, 32'd0);
    chk("t1_no_orphan", {31'd0, err_orphan}, 32'd0);

    // Both requests held: alternation, gap spacing, tag FIFO fill
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    budget = 0;
    while (n_eop < 4 && budget < 1000) begin step(); budget++; end
    chk("t2_four_frames", {31'd0, n_eop >= 4}, 32'd1);
    repeat (20) step();
    chk("t2_n_sop_full", n_sop, 4);
    chk("t2_order", {28'd0, sop_ch[0], sop_ch[1], sop_ch[2], sop_ch[3]}, 32'b0101);
    chk("t2_space01", sop_cyc[1] - sop_cyc[0], 135);
    chk("t2_space12", sop_cyc[2] - sop_cyc[1], 135);
    chk("t2_space23", sop_cyc[3] - sop_cyc[2], 135);
    chk("t2_overlap", n_ovl, 0);
    chk("t2_n_rd0", n_rd0, 264);
    chk("t2_n_rd1", n_rd1, 264);
    chk("t2_stalled_rd", {30'd0, rd_en0, rd_en1}, 32'd0);
    chk("t2_busy_full", {31'd0, busy}, 32'd1);
    pulses(120, 4'b0000, "t2_pop");
    budget = 0;
    while (n_sop < 5 && budget < 20) begin step(); budget++; end
    chk("t2_regrant", {31'd0, n_sop >= 5}, 32'd1);
    chk("t2_regrant_ch", {31'd0, sop_ch[4]}, 32'd0);

    // Output tagging: ch1 frame then ch0 frame
    do_reset();
    step();
    req1 = 1'b1;
    step();
    req1 = 1'b0;
    req0 = 1'b1;
    seen = 1'b0;
    budget = 0;
    while (!seen && budget < 300) begin
      step();
      seen = rd_en0;
      budget++;
    end
    req0 = 1'b0;
    chk("t4_ch0_granted", {31'd0, seen}, 32'd1);
    repeat (140) step();
    chk("t4_n_sop", n_sop, 2);
    chk("t4_order", {30'd0, sop_ch[0], sop_ch[1]}, 32'b10);
    chk("t4_ch1_first_sym", {24'd0, sop_dat[0]}, 32'h40);
    pulses(240, 4'b0001, "t4_tag");
    step();
    chk("t4_busy_idle", {31'd0, busy}, 32'd0);
    chk("t4_no_orphan", {31'd0, err_orphan}, 32'd0);

    // Orphan decoder output sets a sticky error
    dec_out_val = 1'b1;
    #1;
    chk("t5_orphan_pre", {31'd0, err_orphan}, 32'd0);
    step();
    dec_out_val = 1'b0;
    chk("t5_orphan_set", {31'd0, err_orphan}, 32'd1);
    repeat (5) step();
    chk("t5_orphan_hold", {31'd0, err_orphan}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("t5_orphan_clr", {31'd0, err_orphan}, 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of a ch1 frame
    do_reset();
    step();
    req1 = 1'b1;
    step();
    req1 = 1'b0;
    chk("t6_rd_en1_start", {31'd0, rd_en1}, 32'd1);
    repeat (50) step();
    chk("t6_mid_frame", {29'd0, rd_en1, dec_din_val, busy}, 32'b111);
    rst_n = 1'b0;
    step();
    chk("t6_after_rst", {29'd0, rd_en1, dec_din_val, busy}, 32'b000);
    rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    step();
    req0 = 1'b0; req1 = 1'b0;
    chk("t6_rr_reset", {30'd0, rd_en0, rd_en1}, 32'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
